// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master.
// The winner's address, data and one-hot select are latched and a one-cycle
// start pulse is sent to the master. The block then waits for CPUPREADY, or
// gives up after TIMEOUT wait cycles, and pulses REQ_DONE/REQ_ERR back to the
// granted requester. Every output comes straight from a flop.
module apb_req_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 21,
  parameter int SEL_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                CCLK,
  input  logic                CPURESET,
  input  logic [1:0]          REQ_VALID,
  input  logic [2*ADDR_W-1:0] REQ_ADDR,
  input  logic [2*DATA_W-1:0] REQ_DATA,
  input  logic [2*SEL_W-1:0]  REQ_SEL,
  output logic [1:0]          GRANT,
  output logic [1:0]          REQ_DONE,
  output logic [1:0]          REQ_ERR,
  output logic [DATA_W-1:0]   RSP_DATA,
  output logic                APBMASTERENABLE,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data,
  output logic [SEL_W-1:0]    CPUSEL,
  input  logic                CPUPREADY,
  input  logic [DATA_W-1:0]   PRDATA
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // index of the current grant
  logic                last_q, last_d;     // index of the last completed grant
  logic                err_q, err_d;       // abort flag carried into DONE
  logic [7:0]          cnt_q, cnt_d;       // wait-cycle counter
  logic [7:0]          cnt_inc;

  logic [1:0]          grant_d, done_d, rerr_d;
  logic [DATA_W-1:0]   rsp_d, data_d;
  logic                en_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [SEL_W-1:0]    sel_d;

  logic                win;
  logic [1:0]          win_oh, owner_oh;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [SEL_W-1:0]    win_sel;
  logic                win_sel_ok;

  // Round-robin pick and the winner's request fields.
  always_comb begin
    // A tie goes to the requester that did not complete last.
    win        = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];
    win_oh     = win ? 2'b10 : 2'b01;
    owner_oh   = owner_q ? 2'b10 : 2'b01;
    win_addr   = win ? REQ_ADDR[2*ADDR_W-1:ADDR_W] : REQ_ADDR[ADDR_W-1:0];
    win_data   = win ? REQ_DATA[2*DATA_W-1:DATA_W] : REQ_DATA[DATA_W-1:0];
    win_sel    = win ? REQ_SEL[2*SEL_W-1:SEL_W]    : REQ_SEL[SEL_W-1:0];
    // One-hot test: non-zero and clearing the lowest set bit leaves nothing.
    win_sel_ok = (win_sel != '0) && ((win_sel & (win_sel - SEL_W'(1))) == '0);
    cnt_inc    = cnt_q + 8'd1;
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    grant_d = GRANT;
    done_d  = '0;
    rerr_d  = '0;
    en_d    = 1'b0;
    rsp_d   = RSP_DATA;
    addr_d  = addr;
    data_d  = data;
    sel_d   = CPUSEL;

    case (state_q)
      IDLE: begin
        if (|REQ_VALID) begin
          owner_d = win;
          grant_d = win_oh;
          addr_d  = win_addr;
          data_d  = win_data;
          sel_d   = win_sel;
          // A malformed select never reaches the APB master.
          err_d   = ~win_sel_ok;
          state_d = win_sel_ok ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion is tested first so it beats a simultaneous timeout.
        if (CPUPREADY) begin
          rsp_d   = PRDATA;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = owner_oh;
        rerr_d  = err_q ? owner_oh : 2'b00;
        grant_d = '0;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of order.
    if (CPURESET) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      last_q          <= 1'b1;   // requester 0 wins the first tie
      err_q           <= 1'b0;
      cnt_q           <= '0;
      GRANT           <= '0;
      REQ_DONE        <= '0;
      REQ_ERR         <= '0;
      RSP_DATA        <= '0;
      APBMASTERENABLE <= 1'b0;
      addr            <= '0;
      data            <= '0;
      CPUSEL          <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_q          <= last_d;
      err_q           <= err_d;
      cnt_q           <= cnt_d;
      GRANT           <= grant_d;
      REQ_DONE        <= done_d;
      REQ_ERR         <= rerr_d;
      RSP_DATA        <= rsp_d;
      APBMASTERENABLE <= en_d;
      addr            <= addr_d;
      data            <= data_d;
      CPUSEL          <= sel_d;
    end
  end

endmodule
